fsub_seq: RTL
=============

Name: fsub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor: out = a - b, round-to-nearest-even.
- Inverse-operation companion to the combinational adder. Intended for the FP execute stage, where the area/latency trade favours an iterative shifter.
- Valid/ready handshake on both sides. One operation in flight at a time.

Parameters:
- CANON_NAN, 32'h7FC0_0000, value returned for every NaN-producing case.
- MAX_ALIGN, 27, exponent difference at or above which the smaller operand collapses to a sticky bit.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands a, b are presented.
- in_ready  out  1  block is idle and accepts operands.
- a  in  32  minuend, IEEE-754 single.
- b  in  32  subtrahend, IEEE-754 single.
- out_valid  out  1  result is held on out.
- out_ready  in  1  consumer accepts the result.
- out  out  32  a - b.
- busy  out  1  high from the accept cycle until the result is consumed.

Behaviour:
- Reset, when rst_n=0 at a posedge: state=IDLE, in_ready=1, out_valid=0, busy=0, out=0.
  - Reset mid-operation aborts the operation with no output.
- Accept: a transfer occurs when in_valid && in_ready at a posedge.
  - a and b are latched, with b's sign inverted.
  - in_ready drops in the next cycle.
  - Inputs are ignored while in_ready=0.
- States:
  - IDLE -> UNPACK on accept.
  - UNPACK: split each operand into sign, exponent and 24-bit significand (hidden 1).
    - Exponent 0 (zero or subnormal) is treated as zero: flush-to-zero.
    - Special cases go straight to DONE:
      - either operand NaN -> CANON_NAN.
      - inf - inf of same sign -> CANON_NAN.
      - one operand inf -> that inf with its effective sign.
      - both operands zero -> +0, except (-0) - (+0) = -0.
      - one operand zero -> the other operand (effective sign).
    - Otherwise: swap so that the larger magnitude is in X; d = exp difference.
    - If d >= MAX_ALIGN, Y is reduced to sticky=1 and the block goes to ADD.
    - Else the block goes to ALIGN.
  - ALIGN: shift Y right by 1 per cycle, ORing shifted-out bits into sticky, and decrement d. Go to ADD when d=0 (at most 26 cycles).
  - ADD: use a 27-bit datapath (significand, guard, round, sticky).
    - Same effective sign: X+Y.
    - Otherwise: X-Y, which is never negative after the swap.
    - Result sign = X sign.
    - Exact-zero difference -> +0 -> DONE.
  - NORM:
    - Carry-out: shift right 1 (keeping sticky), exp+1, done in 1 cycle.
    - Else while MSB=0: shift left 1 per cycle, exp-1 (at most 24 cycles).
    - If exp reaches 0 -> signed zero (flush) -> DONE.
  - ROUND: RNE using guard | (round|sticky) | lsb.
    - A mantissa carry increments exp.
    - exp=255 -> signed infinity.
    - Then go to DONE.
  - DONE: out_valid=1 and out is stable. On out_ready -> IDLE, out_valid=0, in_ready=1 next cycle.
- Latency:
  - Accept to out_valid is 2 cycles minimum (specials).
  - General case is 4 + d + normalization shifts.
  - Worst case is at most 56 cycles.
- Back-pressure: out is held indefinitely while out_ready=0.
- Same-cycle: out_ready and in_valid in the DONE cycle does not accept. in_ready rises only in IDLE.

Decomposition:
- Shared package fp_pkg:
  - field widths: EXP_W=8, MAN_W=23, BIAS=127.
  - CANON_NAN constant.
  - state enum {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE}.
  - unpacked-operand struct: sign, exp, sig[23:0], is_zero, is_inf, is_nan.
- One natural sub-module: fp_classify (combinational unpack and classify).
  - One instance per operand.
  - Reusable by the adder and future FP units.

Test Plan:
- 40400000 - 3F800000 -> 40000000 (3-1=2, d=1). Also 3FC00000 - 3E800000 -> 3FA00000 (1.5-0.25, d=2).
- 3F800000 - 33000000 -> 3F800000 (RNE tie to even). 3F800000 - 30800000 -> 3F800000 (d>=MAX_ALIGN, sticky path).
- 3F800000 - 3F800000 -> 00000000. 3F800000 - BF800000 -> 40000000 (effective add). 40000000 - 3FFFFFFF -> 34000000 (massive left normalization).
- 7F800000 - 3F800000 -> 7F800000. 7F800000 - 7F800000 -> 7FC00000. 7FC00001 - 0 -> 7FC00000. Check 2-cycle latency for all three.
- Hold out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0, new in_valid ignored. Release -> one transfer, then the next operands are accepted.
- Assert rst_n=0 during ALIGN -> next cycle out_valid=0, in_ready=1, busy=0. A subsequent operation is computed correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the FP execute-stage units.
package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int BIAS      = 127;
    localparam int MAX_ALIGN = 27;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack and classification of one single-precision operand.
// Subnormals are flushed: exponent 0 always reports zero with a zero significand.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]  word,
    output fp_unpacked_t op
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f = word[30:23];
    assign man_f = word[22:0];

    always_comb begin
        op.sign    = word[31];
        op.exp     = exp_f;
        op.is_zero = (exp_f == '0);
        op.is_inf  = (exp_f == '1) && (man_f == '0);
        op.is_nan  = (exp_f == '1) && (man_f != '0);
        op.sig     = op.is_zero ? '0 : {1'b1, man_f};
    end

endmodule

// File: rtl/fsub_seq.sv
// Iterative single-precision subtractor (a - b, RNE) with valid/ready on both sides.
// The subtrahend's sign is flipped at accept so the datapath is a plain signed add.
module fsub_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        busy
);

    state_t       state, state_n;
    logic [31:0]  a_q, a_n, b_q, b_n, out_q, out_n;
    logic         eff_sub, eff_sub_n, r_sign, r_sign_n;
    logic [8:0]   r_exp, r_exp_n;
    logic [26:0]  x_m, x_m_n, y_m, y_m_n;
    logic [27:0]  r_m, r_m_n;
    logic [7:0]   d, d_n;

    fp_unpacked_t ca, cb, xo, yo;
    logic         a_big;
    logic [7:0]   diff;
    logic [27:0]  sum;
    logic         rnd_inc;
    logic [24:0]  rnd_m;
    logic [8:0]   rnd_e;
    logic [22:0]  rnd_frac;

    fp_classify u_cls_a (.word(a_q), .op(ca));
    fp_classify u_cls_b (.word(b_q), .op(cb));

    // X always holds the larger magnitude, so X - Y never goes negative.
    assign a_big = {ca.exp, ca.sig} >= {cb.exp, cb.sig};
    assign xo    = a_big ? ca : cb;
    assign yo    = a_big ? cb : ca;
    assign diff  = xo.exp - yo.exp;

    assign sum = eff_sub ? ({1'b0, x_m} - {1'b0, y_m}) : ({1'b0, x_m} + {1'b0, y_m});

    // r_m[26:3] significand, [2] guard, [1] round, [0] sticky.
    assign rnd_inc  = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
    assign rnd_m    = {1'b0, r_m[26:3]} + 25'(rnd_inc);
    assign rnd_e    = r_exp + 9'(rnd_m[24]);
    assign rnd_frac = rnd_m[24] ? rnd_m[23:1] : rnd_m[22:0];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out       = out_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        a_n       = a_q;
        b_n       = b_q;
        out_n     = out_q;
        eff_sub_n = eff_sub;
        r_sign_n  = r_sign;
        r_exp_n   = r_exp;
        x_m_n     = x_m;
        y_m_n     = y_m;
        r_m_n     = r_m;
        d_n       = d;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_n     = a;
                    b_n     = {~b[31], b[30:0]};
                    state_n = UNPACK;
                end
            end
            UNPACK: begin
                state_n = DONE;
                if (ca.is_nan || cb.is_nan) begin
                    out_n = CANON_NAN;
                end else if (ca.is_inf && cb.is_inf) begin
                    out_n = (ca.sign != cb.sign) ? CANON_NAN : {ca.sign, 8'hFF, 23'd0};
                end else if (ca.is_inf) begin
                    out_n = {ca.sign, 8'hFF, 23'd0};
                end else if (cb.is_inf) begin
                    out_n = {cb.sign, 8'hFF, 23'd0};
                end else if (ca.is_zero && cb.is_zero) begin
                    out_n = {ca.sign & cb.sign, 31'd0};
                end else if (ca.is_zero) begin
                    out_n = b_q;
                end else if (cb.is_zero) begin
                    out_n = a_q;
                end else begin
                    eff_sub_n = ca.sign ^ cb.sign;
                    r_sign_n  = xo.sign;
                    r_exp_n   = {1'b0, xo.exp};
                    x_m_n     = {xo.sig, 3'b000};
                    if (diff >= 8'(MAX_ALIGN)) begin
                        y_m_n   = 27'd1;
                        state_n = ADD;
                    end else begin
                        y_m_n   = {yo.sig, 3'b000};
                        d_n     = diff;
                        state_n = (diff == 8'd0) ? ADD : ALIGN;
                    end
                end
            end
            ALIGN: begin
                y_m_n = {1'b0, y_m[26:2], y_m[1] | y_m[0]};
                d_n   = d - 8'd1;
                if (d == 8'd1) state_n = ADD;
            end
            ADD: begin
                if (sum == '0) begin
                    out_n   = 32'd0;
                    state_n = DONE;
                end else begin
                    r_m_n   = sum;
                    state_n = NORM;
                end
            end
            NORM: begin
                if (r_m[27]) begin
                    r_m_n   = {1'b0, r_m[27:2], r_m[1] | r_m[0]};
                    r_exp_n = r_exp + 9'd1;
                    state_n = ROUND;
                end else if (r_m[26]) begin
                    state_n = ROUND;
                end else if (r_exp == 9'd1) begin
                    out_n   = {r_sign, 31'd0};
                    state_n = DONE;
                end else begin
                    r_m_n   = {r_m[26:0], 1'b0};
                    r_exp_n = r_exp - 9'd1;
                end
            end
            ROUND: begin
                out_n   = (rnd_e >= 9'd255) ? {r_sign, 8'hFF, 23'd0}
                                            : {r_sign, rnd_e[7:0], rnd_frac};
                state_n = DONE;
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears just the
    // control state and the visible result, datapath registers are don't-care until loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out_q <= 32'd0;
        end else begin
            state <= state_n;
            out_q <= out_n;
        end
    end

    always_ff @(posedge clk) begin
        a_q     <= a_n;
        b_q     <= b_n;
        eff_sub <= eff_sub_n;
        r_sign  <= r_sign_n;
        r_exp   <= r_exp_n;
        x_m     <= x_m_n;
        y_m     <= y_m_n;
        r_m     <= r_m_n;
        d       <= d_n;
    end

endmodule
